smem_arbiter: RTL and testbench
===============================

# smem_arbiter

Single-port bus arbiter sharing the synchronous system memory (smem, 1-cycle read latency) between the 65C02 core and a secondary DMA requester, such as a UART program loader or debug port. It sits between the CPU bus and the smem instance. The CPU is stalled through its RDY input on any cycle the DMA port owns memory. The block also supplies CPU read data so that stalls never corrupt an in-flight read. A run-length limit keeps DMA bursts from starving the CPU.

## Interface
- MAX_DMA_RUN, 4, maximum consecutive DMA-owned cycles before one CPU cycle is forced; 0 = unlimited (DMA always wins).
- AW, 16, address width.
- DW, 8, data width.

- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- cpu_ab  in  AW  CPU address.
- cpu_do  in  DW  CPU write data.
- cpu_we  in  1  CPU write strobe.
- cpu_sel  in  1  1 = CPU address decodes to RAM (from glue decode); 0 = I/O such as ACIA.
- cpu_rdy  out  1  to CPU RDY; 0 stalls the current CPU cycle.
- cpu_di  out  DW  RAM read data to the CPU data mux.
- dma_req  in  1  DMA request; address, data and we are held stable while high.
- dma_we  in  1  1 = write, 0 = read.
- dma_addr  in  AW  DMA address.
- dma_wdata  in  DW  DMA write data.
- dma_gnt  out  1  request accepted this cycle; the requester advances to the next transfer.
- dma_rvalid  out  1  one-cycle pulse: dma_rdata is valid.
- dma_rdata  out  DW  DMA read data.
- mem_addr  out  AW  to smem address.
- mem_data  out  DW  to smem data.
- mem_wren  out  1  to smem wren.
- mem_q  in  DW  smem read data; valid the cycle after the address.

## Operation
- Ownership is decided combinationally every cycle.
  - dma_win = dma_req & (MAX_DMA_RUN == 0 | run_cnt < MAX_DMA_RUN).
  - dma_gnt = dma_win. cpu_rdy = ~dma_win.
- DMA-owned cycle:
  - mem_addr = dma_addr, mem_data = dma_wdata, mem_wren = dma_we.
  - The CPU's presented address is ignored. The CPU re-presents it and it is serviced when cpu_rdy returns to 1.
- CPU-owned cycle:
  - mem_addr = cpu_ab, mem_data = cpu_do, mem_wren = cpu_we & cpu_sel.
  - I/O writes (cpu_sel = 0) never reach RAM.
- run_cnt (width clog2(MAX_DMA_RUN+1)):
  - Increments on each DMA-owned cycle, saturating at MAX_DMA_RUN.
  - Clears on any CPU-owned cycle, whether the CPU was requesting or idle.
  - At MAX_DMA_RUN with dma_req still high, exactly one CPU cycle is forced, then DMA resumes.
- Registered tags, set at every clock from the current cycle's ownership:
  - cpu_rd_q = CPU-owned & ~cpu_we.
  - dma_rd_q = dma_win & ~dma_we.
- CPU read data:
  - cpu_di = cpu_rd_q ? mem_q : cpu_di_hold.
  - cpu_di_hold <= mem_q whenever cpu_rd_q = 1.
  - Result: CPU read data stays valid through any number of following stall cycles.
- DMA read data: dma_rvalid = dma_rd_q; dma_rdata = mem_q.
- Writes are posted. There is no completion pulse for a DMA write; dma_gnt suffices.

## Timing
- Reset (reset = 0 at a clock edge) clears run_cnt, cpu_rd_q, dma_rd_q and cpu_di_hold to 0.
- Outputs while reset is held low, regardless of inputs:
  - cpu_rdy = 1, dma_gnt = 0.
  - mem_wren = 0, and mem_addr = cpu_ab.
  - dma_rvalid = 0, cpu_di = 0.
- Reset mid-DMA: a pending read tag is dropped and no dma_rvalid is issued. The requester must reissue.
- Grant latency: dma_gnt is asserted in the same cycle as dma_req when the DMA wins. The write occurs on that edge. Read data arrives at cycle +1 with dma_rvalid.
- Back-to-back DMA: one transfer per cycle while dma_gnt = 1. Read data is pipelined, one per cycle.
- Simultaneous CPU access and dma_req: DMA wins unless the run limit is reached.
- run_cnt saturation: a forced CPU cycle occurs regardless of cpu_sel. An I/O CPU cycle still consumes the slot.
- Combinational paths: dma_req to cpu_rdy, and to the mem_* outputs.

## Test plan
- Idle DMA, CPU writes 0x5A to 0x0200 then reads it -> mem_wren = 1 for one cycle, cpu_rdy stays 1, cpu_di = 0x5A the cycle after the read address.
- CPU reads 0x0300 (holding 0x11); dma_req asserted for 3 cycles in the next cycle -> cpu_rdy = 0 for 3 cycles, cpu_di holds 0x11 throughout and on the first cpu_rdy = 1 cycle.
- MAX_DMA_RUN = 4, dma_req held for 10 cycles -> dma_gnt pattern 1111 0 1111 0, cpu_rdy the inverse, run_cnt never exceeds 4.
- DMA write 0xA5 to 0x1000, then DMA read of 0x1000 in the next cycle -> dma_rvalid pulses one cycle after the read grant with dma_rdata = 0xA5.
- CPU write with cpu_sel = 0 (address 0x8400) -> mem_wren = 0, RAM at 0x8400 unchanged.
- reset pulled low in the cycle after a DMA read grant -> no dma_rvalid, cpu_rdy = 1, cpu_di = 0, run_cnt = 0 after release.

Source files
------------

// File: rtl/smem_arbiter.sv
// Shares the single-port synchronous smem between the 65C02 and a DMA requester.
// DMA wins each cycle unless its run-length budget is spent; CPU read data is held across stalls.
module smem_arbiter #(
    parameter int MAX_DMA_RUN = 4,
    parameter int AW          = 16,
    parameter int DW          = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] cpu_ab,
    input  logic [DW-1:0] cpu_do,
    input  logic          cpu_we,
    input  logic          cpu_sel,
    output logic          cpu_rdy,
    output logic [DW-1:0] cpu_di,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_gnt,
    output logic          dma_rvalid,
    output logic [DW-1:0] dma_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_data,
    output logic          mem_wren,
    input  logic [DW-1:0] mem_q
);

    // A zero limit means unlimited; keep the counter one bit wide so it still exists.
    localparam int            CW      = (MAX_DMA_RUN == 0) ? 1 : $clog2(MAX_DMA_RUN + 1);
    localparam logic [CW-1:0] RUN_MAX = CW'(MAX_DMA_RUN);

    logic [CW-1:0] run_cnt_q, run_cnt_d;
    logic          cpu_rd_q, cpu_rd_d;
    logic          dma_rd_q, dma_rd_d;
    logic [DW-1:0] cpu_di_hold_q, cpu_di_hold_d;
    logic          dma_win;

    always_comb begin
        dma_win       = reset && dma_req && ((MAX_DMA_RUN == 0) || (run_cnt_q < RUN_MAX));
        dma_gnt       = dma_win;
        cpu_rdy       = ~dma_win;

        mem_addr      = cpu_ab;
        mem_data      = cpu_do;
        mem_wren      = reset & cpu_we & cpu_sel;
        if (dma_win) begin
            mem_addr = dma_addr;
            mem_data = dma_wdata;
            mem_wren = dma_we;
        end

        run_cnt_d     = '0;
        if (dma_win)
            run_cnt_d = (run_cnt_q == RUN_MAX) ? run_cnt_q : run_cnt_q + 1'b1;

        cpu_rd_d      = reset & ~dma_win & ~cpu_we;
        dma_rd_d      = dma_win & ~dma_we;

        // Hold register tracks the last CPU read so stalls replay it to the CPU mux.
        cpu_di_hold_d = cpu_rd_q ? mem_q : cpu_di_hold_q;
        cpu_di        = '0;
        if (reset)
            cpu_di = cpu_rd_q ? mem_q : cpu_di_hold_q;

        dma_rvalid    = reset & dma_rd_q;
        dma_rdata     = mem_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            run_cnt_q     <= '0;
            cpu_rd_q      <= 1'b0;
            dma_rd_q      <= 1'b0;
            cpu_di_hold_q <= '0;
        end else begin
            run_cnt_q     <= run_cnt_d;
            cpu_rd_q      <= cpu_rd_d;
            dma_rd_q      <= dma_rd_d;
            cpu_di_hold_q <= cpu_di_hold_d;
        end
    end

endmodule

// File: tb/tb_smem_arbiter.sv
// Vector-table bench for smem_arbiter with a behavioural smem and a DMA read-data scoreboard.
module tb_smem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_ab;
    logic [7:0]  cpu_do;
    logic        cpu_we, cpu_sel;
    logic        cpu_rdy;
    logic [7:0]  cpu_di;
    logic        dma_req, dma_we;
    logic [15:0] dma_addr;
    logic [7:0]  dma_wdata;
    logic        dma_gnt, dma_rvalid;
    logic [7:0]  dma_rdata;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_wren;
    logic [7:0]  mem_q;

    smem_arbiter #(.MAX_DMA_RUN(4), .AW(16), .DW(8)) dut (
        .clk(clk), .reset(reset),
        .cpu_ab(cpu_ab), .cpu_do(cpu_do), .cpu_we(cpu_we), .cpu_sel(cpu_sel),
        .cpu_rdy(cpu_rdy), .cpu_di(cpu_di),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q)
    );

    always #5 clk = ~clk;

    // Behavioural smem: registered read, write on the same edge.
    logic [7:0] mem [0:65535];
    logic       preload;
    always @(posedge clk) begin
        if (preload) begin
            for (int a = 0; a < 65536; a++) mem[a] <= 8'h00;
            mem[16'h0300] <= 8'h11;
            mem[16'h8400] <= 8'h3C;
        end else if (mem_wren) begin
            mem[mem_addr] <= mem_data;
        end
        mem_q <= mem[mem_addr];
    end

    typedef struct {
        logic        rst, req, dwe;
        logic [15:0] daddr;
        logic [7:0]  dwd;
        logic [15:0] cab;
        logic [7:0]  cdo;
        logic        cwe, csel;
        logic        e_rdy, e_gnt, e_wren;
        logic        chk_di;
        logic [7:0]  e_di;
        logic [7:0]  e_rd;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] sb[$];
    int         checks = 0;
    int         errors = 0;

    task automatic v(input logic rst, req, dwe, input logic [15:0] daddr, input logic [7:0] dwd,
                     input logic [15:0] cab, input logic [7:0] cdo, input logic cwe, csel,
                     input logic e_rdy, e_gnt, e_wren, chk_di, input logic [7:0] e_di, e_rd);
        vec_t t;
        t.rst = rst; t.req = req; t.dwe = dwe; t.daddr = daddr; t.dwd = dwd;
        t.cab = cab; t.cdo = cdo; t.cwe = cwe; t.csel = csel;
        t.e_rdy = e_rdy; t.e_gnt = e_gnt; t.e_wren = e_wren;
        t.chk_di = chk_di; t.e_di = e_di; t.e_rd = e_rd;
        vecs.push_back(t);
    endtask

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    initial begin
        vec_t c;
        logic pend, rv_exp;
        logic [7:0] exp_rd;

        // reset held with all requests active
        v(0,1,1,16'h1000,8'hEE,16'h1234,8'h55,1,1, 1,0,0, 1,8'h00,8'h00);
        v(0,1,1,16'h1000,8'hEE,16'h1234,8'h55,1,1, 1,0,0, 1,8'h00,8'h00);
        // CPU write 0x5A @0200, read it back
        v(1,0,0,16'h0000,8'h00,16'h0200,8'h5A,1,1, 1,0,1, 1,8'h00,8'h00);
        v(1,0,0,16'h0000,8'h00,16'h0200,8'h00,0,1, 1,0,0, 1,8'h00,8'h00);
        v(1,0,0,16'h0000,8'h00,16'h0300,8'h00,0,1, 1,0,0, 1,8'h5A,8'h00);
        // 3 DMA reads stall the CPU; 0x11 from 0300 held on cpu_di
        for (int i = 0; i < 3; i++)
            v(1,1,0,16'h0300,8'h00,16'h0304,8'h00,0,1, 0,1,0, 1,8'h11,8'h11);
        v(1,0,0,16'h0000,8'h00,16'h0304,8'h00,0,1, 1,0,0, 1,8'h11,8'h00);
        // run limit: 10 cycles of DMA writes -> 1111 0 1111 0
        for (int i = 0; i < 10; i++) begin
            logic g;
            g = (i % 5) != 4;
            v(1,1,1,16'h2000,8'h77,16'h0400,8'h00,0,1, !g,g,g, 0,8'h00,8'h00);
        end
        // DMA write A5 @1000 then read back
        v(1,1,1,16'h1000,8'hA5,16'h0400,8'h00,0,1, 0,1,1, 0,8'h00,8'h00);
        v(1,1,0,16'h1000,8'h00,16'h0400,8'h00,0,1, 0,1,0, 0,8'h00,8'hA5);
        v(1,0,0,16'h0000,8'h00,16'h0400,8'h00,0,1, 1,0,0, 0,8'h00,8'h00);
        // I/O write to 8400 must not reach RAM
        v(1,0,0,16'h0000,8'h00,16'h8400,8'h99,1,0, 1,0,0, 0,8'h00,8'h00);
        v(1,0,0,16'h0000,8'h00,16'h8400,8'h00,0,1, 1,0,0, 0,8'h00,8'h00);
        v(1,0,0,16'h0000,8'h00,16'h8400,8'h00,0,1, 1,0,0, 1,8'h3C,8'h00);
        // DMA read grant then reset: read tag dropped
        v(1,1,0,16'h1000,8'h00,16'h8400,8'h00,0,1, 0,1,0, 1,8'h3C,8'hA5);
        v(0,1,0,16'h1000,8'h00,16'h1234,8'h00,1,1, 1,0,0, 1,8'h00,8'h00);
        // after release run_cnt restarts at 0
        for (int i = 0; i < 5; i++) begin
            logic g;
            g = i < 4;
            v(1,1,1,16'h3000,8'h42,16'h0500,8'h00,0,1, !g,g,g, (i == 0),8'h00,8'h00);
        end
        v(1,1,0,16'h3000,8'h00,16'h0500,8'h00,0,1, 0,1,0, 0,8'h00,8'h42);
        v(1,0,0,16'h0000,8'h00,16'h2000,8'h00,0,1, 1,0,0, 0,8'h00,8'h00);
        v(1,0,0,16'h0000,8'h00,16'h2000,8'h00,0,1, 1,0,0, 1,8'h77,8'h00);

        preload = 1'b1;
        reset = 1'b0; dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
        cpu_ab = '0; cpu_do = '0; cpu_we = 1'b0; cpu_sel = 1'b0;
        @(posedge clk); #1;
        preload = 1'b0;
        pend = 1'b0;

        foreach (vecs[i]) begin
            c = vecs[i];
            reset = c.rst; dma_req = c.req; dma_we = c.dwe; dma_addr = c.daddr; dma_wdata = c.dwd;
            cpu_ab = c.cab; cpu_do = c.cdo; cpu_we = c.cwe; cpu_sel = c.csel;
            @(negedge clk);
            check($sformatf("v%0d_cpu_rdy", i), 16'(cpu_rdy), 16'(c.e_rdy));
            check($sformatf("v%0d_dma_gnt", i), 16'(dma_gnt), 16'(c.e_gnt));
            check($sformatf("v%0d_mem_wren", i), 16'(mem_wren), 16'(c.e_wren));
            check($sformatf("v%0d_mem_addr", i), mem_addr, c.e_gnt ? c.daddr : c.cab);
            if (c.e_wren)
                check($sformatf("v%0d_mem_data", i), 16'(mem_data), 16'(c.e_gnt ? c.dwd : c.cdo));
            if (c.chk_di)
                check($sformatf("v%0d_cpu_di", i), 16'(cpu_di), 16'(c.e_di));
            rv_exp = pend && c.rst;
            if (pend && !c.rst && sb.size() > 0) void'(sb.pop_front());
            check($sformatf("v%0d_dma_rvalid", i), 16'(dma_rvalid), 16'(rv_exp));
            if (rv_exp && sb.size() > 0) begin
                exp_rd = sb.pop_front();
                if (dma_rvalid)
                    check($sformatf("v%0d_dma_rdata", i), 16'(dma_rdata), 16'(exp_rd));
            end
            pend = c.e_gnt && !c.dwe;
            if (pend) sb.push_back(c.e_rd);
            @(posedge clk); #1;
        end

        check("sb_drained", 16'(sb.size()), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
